// File: rtl/shnorm_pkg.sv
// Shared widths, FSM state type and per-cycle shift-amount table for shift_normalize.
// Optional sign-normalize mode is enabled by defining SHNORM_SIGNED_EN.
package shnorm_pkg;

    localparam int DATA_W     = 32;
    localparam int CNT_W      = 6;
    localparam int NUM_STAGES = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STAGE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Index 0 is applied first: 16, 8, 4, 2, 1.
    localparam logic [NUM_STAGES-1:0][CNT_W-1:0] STAGE_K = {
        6'd1, 6'd2, 6'd4, 6'd8, 6'd16
    };

endpackage

// File: rtl/shnorm_stage.sv
// One normalize step: tests the top bits of the working value and shifts left by k when allowed.
// Mode 0 needs the top k bits clear; Mode 1 needs the top k+1 bits all equal (sign extension).
module shnorm_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic [DATA_W-1:0] value_i,
    input  logic [CNT_W-1:0]  k_i,
    input  logic              mode_i,
    output logic [DATA_W-1:0] shifted_o,
    output logic              take_o
);

    logic [DATA_W-1:0] mask_k;
    logic [DATA_W-1:0] mask_k1;
    logic [DATA_W-1:0] top_k1;

    assign mask_k  = ~({DATA_W{1'b1}} >> k_i);
    assign mask_k1 = ~({DATA_W{1'b1}} >> (k_i + 1'b1));
    assign top_k1  = value_i & mask_k1;

    assign take_o    = mode_i ? ((top_k1 == '0) || (top_k1 == mask_k1))
                              : ((value_i & mask_k) == '0);
    assign shifted_o = value_i << k_i;

endmodule

// File: rtl/shift_normalize.sv
// Multi-cycle left normalizer: five binary-search shift steps reuse one shnorm_stage.
// Define SHNORM_SIGNED_EN to add the Mode input (sign normalize); default build is leading-zero only.
module shift_normalize #(
    parameter int DATA_W = shnorm_pkg::DATA_W,
    parameter int CNT_W  = shnorm_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] A,
`ifdef SHNORM_SIGNED_EN
    input  logic              Mode,
`endif
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] S,
    output logic [CNT_W-1:0]  Cnt,
    output logic              Zero
);

    import shnorm_pkg::*;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [2:0]        idx_q, idx_d;
    logic              azero_q, azero_d;
    logic [DATA_W-1:0] s_q, s_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              zero_q, zero_d;
    logic              stage_mode;

    logic [CNT_W-1:0]  stage_k;
    logic [DATA_W-1:0] stage_shifted;
    logic              stage_take;

`ifdef SHNORM_SIGNED_EN
    logic mode_q, mode_d;
    assign stage_mode = mode_q;
`else
    assign stage_mode = 1'b0;
`endif

    assign stage_k = STAGE_K[idx_q];

    shnorm_stage #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_stage (
        .value_i   (val_q),
        .k_i       (stage_k),
        .mode_i    (stage_mode),
        .shifted_o (stage_shifted),
        .take_o    (stage_take)
    );

    // NOTE: every signal gets its hold value first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        azero_d = azero_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
`ifdef SHNORM_SIGNED_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = STAGE;
                    val_d   = A;
                    wcnt_d  = '0;
                    idx_d   = '0;
                    azero_d = (A == '0);
`ifdef SHNORM_SIGNED_EN
                    mode_d  = Mode;
`endif
                end
            end
            STAGE: begin
                if (stage_take) begin
                    val_d  = stage_shifted;
                    wcnt_d = wcnt_q + stage_k;
                end
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'(NUM_STAGES - 1)) begin
                    state_d = DONE;
                    idx_d   = '0;
                    s_d     = val_d;
                    zero_d  = azero_q;
                    // Leading-zero count of 0 is the full width; the step chain alone stops at 31.
                    cnt_d   = (azero_q && !stage_mode) ? CNT_W'(DATA_W) : wcnt_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            val_q   <= '0;
            wcnt_q  <= '0;
            idx_q   <= '0;
            azero_q <= 1'b0;
            s_q     <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
`ifdef SHNORM_SIGNED_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            azero_q <= azero_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
`ifdef SHNORM_SIGNED_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign busy = (state_q == STAGE);
    assign done = (state_q == DONE);
    assign S    = s_q;
    assign Cnt  = cnt_q;
    assign Zero = zero_q;

endmodule

// File: tb/tb_shift_normalize.sv
// Directed self-checking bench for shift_normalize; Mode 1 vectors run only with SHNORM_SIGNED_EN.
module tb_shift_normalize;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
`ifdef SHNORM_SIGNED_EN
    logic        mode;
`endif
    logic        busy;
    logic        done;
    logic [31:0] s;
    logic [5:0]  cnt;
    logic        zero;

    int checks = 0;
    int errors = 0;

    shift_normalize dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (a),
`ifdef SHNORM_SIGNED_EN
        .Mode  (mode),
`endif
        .busy  (busy),
        .done  (done),
        .S     (s),
        .Cnt   (cnt),
        .Zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Raise start now, let the next rising edge sample it, then drop it 1 ns after that edge.
    task automatic issue_start(input logic [31:0] value);
        a     = value;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called 1 ns after the accepting edge: four STAGE-cycle edges with no done, then the result.
    task automatic expect_result(input string tag, input logic [31:0] exp_s,
                                 input logic [5:0] exp_cnt, input logic exp_zero);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_early_done"}, 32'(done), 32'd0);
        end
        @(posedge clk);
        #1;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
        check({tag, "_S"}, s, exp_s);
        check({tag, "_Cnt"}, 32'(cnt), 32'(exp_cnt));
        check({tag, "_Zero"}, 32'(zero), 32'(exp_zero));
    endtask

    task automatic run_op(input string tag, input logic [31:0] value, input logic [31:0] exp_s,
                          input logic [5:0] exp_cnt, input logic exp_zero);
        @(negedge clk);
        issue_start(value);
        expect_result(tag, exp_s, exp_cnt, exp_zero);
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, 32'(done), 32'd0);
        check({tag, "_S_hold"}, s, exp_s);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
`ifdef SHNORM_SIGNED_EN
        mode  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_S", s, 32'd0);
        check("rst_Cnt", 32'(cnt), 32'd0);
        check("rst_Zero", 32'(zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("m0_one", 32'h0000_0001, 32'h8000_0000, 6'd31, 1'b0);
        run_op("m0_f0", 32'h00F0_0000, 32'hF000_0000, 6'd8, 1'b0);
        run_op("m0_msb", 32'h8000_0000, 32'h8000_0000, 6'd0, 1'b0);
        run_op("m0_zero", 32'h0000_0000, 32'h0000_0000, 6'd32, 1'b1);
        run_op("m0_mid", 32'h0001_2345, 32'h91A2_8000, 6'd15, 1'b0);

        // Start while busy must be ignored: result stays that of A=1, exactly one done.
        @(negedge clk);
        issue_start(32'h0000_0001);
        for (int i = 1; i <= 9; i++) begin
            if (i == 2) begin
                a     = 32'h00F0_0000;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            check("ign_done", 32'(done), (i == 5) ? 32'd1 : 32'd0);
            if (i == 5) begin
                check("ign_S", s, 32'h8000_0000);
                check("ign_Cnt", 32'(cnt), 32'd31);
            end
        end

        // Back-to-back: start asserted during the DONE cycle.
        @(negedge clk);
        issue_start(32'h8000_0000);
        expect_result("b2b_first", 32'h8000_0000, 6'd0, 1'b0);
        issue_start(32'h00F0_0000);
        expect_result("b2b_second", 32'hF000_0000, 6'd8, 1'b0);

        // Reset mid-operation clears outputs at once and discards the in-flight result.
        @(negedge clk);
        issue_start(32'h0000_0001);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_S", s, 32'd0);
        check("mid_rst_Cnt", 32'(cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_done", 32'(done), 32'd0);
        end
        run_op("post_rst", 32'h00F0_0000, 32'hF000_0000, 6'd8, 1'b0);

`ifdef SHNORM_SIGNED_EN
        mode = 1'b1;
        run_op("m1_neg", 32'hFFFF_8000, 32'h8000_0000, 6'd16, 1'b0);
        run_op("m1_one", 32'h0000_0001, 32'h4000_0000, 6'd30, 1'b0);
        run_op("m1_zero", 32'h0000_0000, 32'h0000_0000, 6'd31, 1'b1);
        run_op("m1_ones", 32'hFFFF_FFFF, 32'h8000_0000, 6'd31, 1'b0);
        mode = 1'b0;
        run_op("m0_again", 32'h0000_0001, 32'h8000_0000, 6'd31, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_normalize.md
SHIFT_NORMALIZE -- requirements
Module: shift_normalize

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, operand width; only 32 is supported.
REQ-002 The block SHALL have parameter CNT_W, default 6, count width, able to hold 0..32.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, request to normalize A; sampled only when busy=0.
REQ-006 The block SHALL have port A, input, 32, operand; captured on an accepted start.
REQ-007 The block SHALL have port Mode, input, 1, 0=leading-zero normalize, 1=sign normalize; captured with A; present only with SHNORM_SIGNED_EN.
REQ-008 The block SHALL have port busy, output, 1, high while an operation is in flight.
REQ-009 The block SHALL have port done, output, 1, single-cycle pulse when S/Cnt/Zero are valid.
REQ-010 The block SHALL have port S, output, 32, normalized value.
REQ-011 The block SHALL have port Cnt, output, 6, left-shift amount applied.
REQ-012 The block SHALL have port Zero, output, 1, high when the captured A was 0.

Function
REQ-013 The block SHALL be the inverse of the ALU logical/arithmetic shift: for nonzero A in Mode 0, logical right shift of S by Cnt SHALL equal A.
REQ-014 FSM states SHALL be IDLE, STAGE, DONE; IDLE->STAGE on accepted start; STAGE holds 5 cycles (k=16,8,4,2,1) then ->DONE; DONE->IDLE after 1 cycle, or ->STAGE if start is high in DONE.
REQ-015 busy SHALL be high in STAGE only; start while busy=1 SHALL be ignored with no effect.
REQ-016 Mode 0, each stage: if the top k bits of the working value are all 0, shift left by k (zero fill) and add k to Cnt.
REQ-017 Mode 1, each stage: if the top k+1 bits are all equal, shift left by k and add k to Cnt; result max 31.
REQ-018 Mode 0 with A=0 SHALL give S=0, Cnt=32, Zero=1; Mode 1 with A=0 or 0xFFFFFFFF SHALL give Cnt=31.
REQ-019 Latency: start sampled at edge N; done SHALL be high in cycle N+6 exactly; S/Cnt/Zero SHALL hold until the next accepted start.
REQ-020 done SHALL not assert for ignored starts; back-to-back start in the DONE cycle SHALL produce done again 6 cycles later.

Reset
REQ-021 reset SHALL force IDLE, busy=0, done=0, S=0, Cnt=0, Zero=0 immediately, including mid-operation; the in-flight result SHALL be discarded.
REQ-022 The first start after reset is deasserted SHALL be accepted normally.

Configuration
REQ-023 With SHNORM_SIGNED_EN defined, the Mode port and REQ-017 behaviour SHALL exist.
REQ-024 Without SHNORM_SIGNED_EN, the Mode port SHALL be absent and the block SHALL behave as Mode 0 only.

Structure
REQ-025 Package shnorm_pkg SHALL hold DATA_W, CNT_W, the state enum (IDLE/STAGE/DONE), and the stage-amount table (16,8,4,2,1).
REQ-026 One combinational sub-module shnorm_stage SHALL exist: inputs value, k, Mode; outputs shifted value and take flag; instantiated once and reused per cycle.

Verification
REQ-027 Mode 0, A=0x00000001 -> S=0x80000000, Cnt=31, Zero=0, done at N+6.
REQ-028 Mode 0, A=0x00F00000 -> S=0xF0000000, Cnt=8; A=0x80000000 -> S=0x80000000, Cnt=0.
REQ-029 Mode 0, A=0 -> S=0, Cnt=32, Zero=1.
REQ-030 Mode 1, A=0xFFFF8000 -> S=0x80000000, Cnt=16; A=0x00000001 -> S=0x40000000, Cnt=30.
REQ-031 start pulsed at N+2 while busy -> ignored, single done at N+6, result from the first A.
REQ-032 reset asserted at N+3 -> busy=0, done=0, S=0, Cnt=0 at once; no done follows; the next start completes correctly.
